// File: rtl/poly_codec_pkg.sv
// Shared definitions for the polynomial coefficient codec (encoder/decoder).
// Holds the encoder state enum, the default coefficient geometry and the
// word <-> coefficient scaling helpers for the default configuration.
// No ports (package).
package poly_codec_pkg;

    localparam int POLY_SIZE    = 16;
    localparam int DATA_WIDTH   = 16;
    localparam int SCALE_FACTOR = 2;
    localparam int CW           = DATA_WIDTH + SCALE_FACTOR;
    localparam int BUS_W        = CW * POLY_SIZE;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } enc_state_e;

    // Word -> coefficient: zero-extend and shift left, no truncation.
    function automatic logic [CW-1:0] scale_up(input logic [DATA_WIDTH-1:0] word);
        return {word, {SCALE_FACTOR{1'b0}}};
    endfunction

    // Coefficient -> word: exact inverse of scale_up.
    function automatic logic [DATA_WIDTH-1:0] scale_down(input logic [CW-1:0] coeff);
        return coeff[CW-1:SCALE_FACTOR];
    endfunction

endpackage

// File: rtl/poly_slot_bank.sv
// Register array of POLY_SIZE coefficients with indexed write, clear-all and
// a flattened read-out (slot i at bits [(i+1)*CW-1 : i*CW]).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (clears all slots)
//   wr_en       - write wr_data into slot wr_idx
//   wr_idx      - target slot
//   wr_data     - coefficient to store
//   clr         - clear every slot (takes priority over a write)
//   slots       - flattened slot contents, straight from the registers
module poly_slot_bank #(
    parameter int POLY_SIZE = 16,
    parameter int CW        = 18,
    parameter int IDX_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [CW-1:0]             wr_data,
    input  logic                      clr,
    output logic [CW*POLY_SIZE-1:0]   slots
);

    logic [POLY_SIZE-1:0][CW-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (wr_en) begin
            slot_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slots = slot_q;

endmodule

// File: rtl/poly_encoder.sv
// Streaming polynomial encoder. Each accepted binary word is scaled up by
// SCALE_FACTOR bits into one coefficient and stored in the next slot; a full
// block (or a flushed partial block, zero-padded) is presented on a
// valid/ready output as the flattened coefficient bus read by the decoder.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input word handshake, binary_data is the word
//   flush                - close a non-empty block early (FILL only)
//   out_valid/out_ready  - block handshake
//   poly_coeff           - flattened coefficients, coeff i at [(i+1)*CW-1 : i*CW]
//   coeff_count          - number of real coefficients in the current block
module poly_encoder
    import poly_codec_pkg::*;
#(
    parameter int POLY_SIZE    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int SCALE_FACTOR = 2,
    parameter int CNT_W        = $clog2(POLY_SIZE + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_WIDTH-1:0]                       binary_data,
    input  logic                                        flush,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [(DATA_WIDTH+SCALE_FACTOR)*POLY_SIZE-1:0] poly_coeff,
    output logic [CNT_W-1:0]                            coeff_count
);

    // Local geometry follows the instance parameters; the package values are
    // the default configuration shared with the decoder.
    localparam int COEF_W = DATA_WIDTH + SCALE_FACTOR;
    localparam int IDX_W  = (POLY_SIZE > 1) ? $clog2(POLY_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(POLY_SIZE - 1);

    enc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;
    logic              wr_en;
    logic              clr;
    logic [COEF_W-1:0] coeff;

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready  = rst_n & (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;
    assign coeff     = {binary_data, {SCALE_FACTOR{1'b0}}};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
                // count_d already includes a coincident accept, so a flush
                // with a word closes at count+1 and an empty flush is dropped.
                if ((accept && count_q == LAST) || (flush && count_d != '0)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    clr     = 1'b1;
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // count equals the real-coefficient count in FILL and holds through HOLD.
    assign coeff_count = count_q;

    poly_slot_bank #(
        .POLY_SIZE (POLY_SIZE),
        .CW        (COEF_W),
        .IDX_W     (IDX_W)
    ) u_slots (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (count_q[IDX_W-1:0]),
        .wr_data (coeff),
        .clr     (clr),
        .slots   (poly_coeff)
    );

endmodule

// File: tb/tb_poly_encoder.sv
// Self-checking bench for poly_encoder: a cycle-level reference model pushes
// each closed block to a scoreboard; blocks are popped and compared when the
// encoder transfers them.
module tb_poly_encoder;
    import poly_codec_pkg::scale_down;

    localparam int PS    = 16;
    localparam int DW    = 16;
    localparam int SF    = 2;
    localparam int CW    = DW + SF;
    localparam int BW    = CW * PS;
    localparam int CNT_W = $clog2(PS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          flush;
    logic          out_ready;
    logic [DW-1:0] binary_data;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] poly_coeff;
    logic [CNT_W-1:0] coeff_count;

    always #5 clk = ~clk;

    poly_encoder #(
        .POLY_SIZE    (PS),
        .DATA_WIDTH   (DW),
        .SCALE_FACTOR (SF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .binary_data (binary_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .poly_coeff  (poly_coeff),
        .coeff_count (coeff_count)
    );

    typedef struct {
        logic [BW-1:0] bus;
        int            cnt;
        logic [DW-1:0] w0;
    } blk_t;

    blk_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            m_hold = 1'b0;
    int            m_cnt  = 0;
    logic [BW-1:0] m_bus  = '0;
    logic [DW-1:0] m_w0   = '0;
    int            n_acc  = 0;

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        blk_t b;
        in_valid    = v;
        binary_data = d;
        flush       = f;
        out_ready   = r;
        @(negedge clk);
        check_val("in_ready", BW'(in_ready), BW'(rst_n && !m_hold));
        check_val("out_valid", BW'(out_valid), BW'(m_hold));
        check_val("coeff_count", BW'(coeff_count), BW'(m_cnt));
        if (rst_n && m_hold && r) begin
            check_val("sb_pending", BW'(sb.size() > 0), BW'(1));
            if (sb.size() > 0) begin
                b = sb.pop_front();
                check_val("block_bus", poly_coeff, b.bus);
                check_val("block_cnt", BW'(coeff_count), BW'(b.cnt));
                check_val("decoded_w0", BW'(scale_down(poly_coeff[CW-1:0])), BW'(b.w0));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            m_hold = 1'b0;
            m_cnt  = 0;
            m_bus  = '0;
        end else if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                m_cnt  = 0;
                m_bus  = '0;
            end
        end else begin
            if (v) begin
                m_bus[m_cnt*CW +: CW] = CW'(d) << SF;
                if (m_cnt == 0) m_w0 = d;
                m_cnt++;
                n_acc++;
            end
            if ((v && m_cnt == PS) || (f && m_cnt > 0)) begin
                m_hold = 1'b1;
                sb.push_back('{m_bus, m_cnt, m_w0});
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, '0, 0, 0);
        cycle(1, 16'hBEEF, 1, 1);
        rst_n = 1'b1;
        check_val("rst_bus", poly_coeff, '0);
        check_val("rst_valid", BW'(out_valid), '0);
        check_val("rst_count", BW'(coeff_count), '0);
    endtask

    initial begin
        logic [BW-1:0] all_max;
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; binary_data = '0;
        do_reset();

        // Full block 1..16 back-to-back, out_ready held high.
        for (int i = 1; i <= PS; i++) cycle(1, DW'(i), 0, 1);
        check_val("full_c0", BW'(poly_coeff[0 +: CW]), BW'(18'h00004));
        check_val("full_c15", BW'(poly_coeff[15*CW +: CW]), BW'(18'h00040));
        cycle(0, '0, 0, 1);

        // All-ones words.
        for (int i = 0; i < PS; i++) cycle(1, 16'hFFFF, 0, 1);
        all_max = {PS{18'h3FFFC}};
        check_val("max_bus", poly_coeff, all_max);
        check_val("max_dec", BW'(scale_down(poly_coeff[7*CW +: CW])), BW'(16'hFFFF));
        cycle(0, '0, 0, 1);

        // Backpressure: block held with in_valid asserted.
        for (int i = 0; i < PS; i++) cycle(1, DW'(16'h0100 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'hDEAD, 0, 0);
            check_val("bp_stable", poly_coeff, m_bus);
        end
        cycle(1, 16'hDEAD, 0, 1);
        cycle(1, 16'h5555, 1, 1);
        check_val("bp_slot0", BW'(poly_coeff[0 +: CW]), BW'(18'h15554));
        cycle(0, '0, 0, 1);

        // Flush after two words.
        cycle(1, 16'h1234, 0, 1);
        cycle(1, 16'h00AB, 0, 1);
        cycle(0, '0, 1, 0);
        check_val("fl_c0", BW'(poly_coeff[0 +: CW]), BW'(18'h048D0));
        check_val("fl_c1", BW'(poly_coeff[CW +: CW]), BW'(18'h002AC));
        check_val("fl_pad", poly_coeff >> (2*CW), '0);
        check_val("fl_cnt", BW'(coeff_count), BW'(2));
        cycle(0, '0, 1, 1);
        // Empty flush: must not open a block (out_valid checked next cycle).
        cycle(0, '0, 1, 1);
        cycle(0, '0, 0, 1);
        // Flush coincident with the third word.
        cycle(1, 16'h0011, 0, 1);
        cycle(1, 16'h0022, 0, 1);
        cycle(1, 16'h0033, 1, 1);
        check_val("flw_cnt", BW'(coeff_count), BW'(3));
        cycle(0, '0, 0, 1);

        // Reset after 7 words, then during HOLD.
        for (int i = 0; i < 7; i++) cycle(1, DW'(16'h0700 + i), 0, 1);
        do_reset();
        for (int i = 0; i < PS; i++) cycle(1, DW'(16'h0A00 + i), 0, 0);
        cycle(0, '0, 0, 0);
        do_reset();
        for (int i = 0; i < PS; i++) cycle(1, DW'(16'hC000 + i), 0, 1);
        check_val("post_rst_c0", BW'(poly_coeff[0 +: CW]), BW'(18'h30000));
        cycle(0, '0, 0, 1);

        // Random stream of 1000 words with gaps and occasional flushes.
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 30000) begin
            cycle($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6);
            guard++;
        end
        check_val("rand_words", BW'(n_acc >= 1000), BW'(1));
        cycle(0, '0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1);
        check_val("sb_drained", BW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
